// File: rtl/rsd_pkg.sv
// rsd_pkg: shared state encoding and default width for the repeated-subtraction divider.
package rsd_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    FIX   = 2'b10,
    DONE  = 2'b11
  } state_e;
  localparam int WIDTH_DEF = 8;
endpackage

// File: rtl/rsd_datapath.sv
// rsd_datapath: remainder/divisor/quotient registers, subtractor and comparator.
// With DIV_SIGNED_EN the operands are loaded as magnitudes and signs are restored on fix.
module rsd_datapath
  import rsd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             sub,
  input  logic             zero,
`ifdef DIV_SIGNED_EN
  input  logic             fix,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ge,
  output logic             dz,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  logic [WIDTH-1:0] rem_q, rem_d, div_q, div_d, quo_q, quo_d;
  logic dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
  logic neg_n_q, neg_n_d, neg_d_q, neg_d_d;
  logic [WIDTH-1:0] mag_n, mag_d;
  assign mag_n = dividend[WIDTH-1] ? -dividend : dividend;
  assign mag_d = divisor[WIDTH-1] ? -divisor : divisor;
`endif
  assign ge = rem_q >= div_q;
  assign dz = div_q == '0;
  assign quotient = quo_q;
  assign remainder = rem_q;
  assign div_by_zero = dbz_q;
  always_comb begin
    rem_d = rem_q;
    div_d = div_q;
    quo_d = quo_q;
    dbz_d = dbz_q;
`ifdef DIV_SIGNED_EN
    neg_n_d = neg_n_q;
    neg_d_d = neg_d_q;
    if (load) begin
      rem_d = mag_n;
      div_d = mag_d;
      quo_d = '0;
      dbz_d = 1'b0;
      neg_n_d = dividend[WIDTH-1];
      neg_d_d = divisor[WIDTH-1];
    end else if (zero) begin
      quo_d = '1;
      dbz_d = 1'b1;
      // restore the original dividend bit pattern from its magnitude
      rem_d = neg_n_q ? -rem_q : rem_q;
    end else if (sub) begin
      rem_d = rem_q - div_q;
      quo_d = quo_q + 1'b1;
    end else if (fix) begin
      quo_d = (neg_n_q ^ neg_d_q) ? -quo_q : quo_q;
      rem_d = neg_n_q ? -rem_q : rem_q;
    end
`else
    if (load) begin
      rem_d = dividend;
      div_d = divisor;
      quo_d = '0;
      dbz_d = 1'b0;
    end else if (zero) begin
      quo_d = '1;
      dbz_d = 1'b1;
    end else if (sub) begin
      rem_d = rem_q - div_q;
      quo_d = quo_q + 1'b1;
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      div_q <= '0;
      quo_q <= '0;
      dbz_q <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_n_q <= 1'b0;
      neg_d_q <= 1'b0;
`endif
    end else begin
      rem_q <= rem_d;
      div_q <= div_d;
      quo_q <= quo_d;
      dbz_q <= dbz_d;
`ifdef DIV_SIGNED_EN
      neg_n_q <= neg_n_d;
      neg_d_q <= neg_d_d;
`endif
    end
  end
endmodule

// File: rtl/repeated_sub_divider.sv
// repeated_sub_divider: FSM-controlled unsigned divider by repeated subtraction.
// Define DIV_SIGNED_EN for two's-complement operands with a sign-fix state.
module repeated_sub_divider
  import rsd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  state_e state_q, state_d;
  logic load, sub, zero, ge, dz;
`ifdef DIV_SIGNED_EN
  logic fix;
`endif
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  always_comb begin
    state_d = state_q;
    load = 1'b0;
    sub = 1'b0;
    zero = 1'b0;
`ifdef DIV_SIGNED_EN
    fix = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        load = start;
        state_d = start ? CHECK : IDLE;
      end
      CHECK: begin
        zero = dz;
        sub = !dz && ge;
`ifdef DIV_SIGNED_EN
        state_d = dz ? DONE : ge ? CHECK : FIX;
`else
        state_d = dz ? DONE : ge ? CHECK : DONE;
`endif
      end
      FIX: begin
`ifdef DIV_SIGNED_EN
        fix = 1'b1;
`endif
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  rsd_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .sub         (sub),
    .zero        (zero),
`ifdef DIV_SIGNED_EN
    .fix         (fix),
`endif
    .dividend    (dividend),
    .divisor     (divisor),
    .ge          (ge),
    .dz          (dz),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );
endmodule

// File: tb/tb_repeated_sub_divider.sv
// tb_repeated_sub_divider: directed vectors with hand-computed quotient, remainder, flag and latency.
module tb_repeated_sub_divider;
`ifdef DIV_SIGNED_EN
  localparam int E = 1;
`else
  localparam int E = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [7:0] quotient, remainder;
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  repeated_sub_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [7:0] a, input logic [7:0] b, input bit noise,
                     input logic [7:0] eq, input logic [7:0] er, input logic ez, input int elat);
    int lat, bcyc;
    @(negedge clk);
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    bcyc = 0;
    while (!done && lat < 600) begin
      if (noise) begin
        start = 1'b1;
        dividend = 8'd3;
        divisor = 8'd0;
      end
      bcyc += int'(busy);
      @(posedge clk);
      #1 lat++;
    end
    bcyc += int'(busy);
    chk($sformatf("%0d/%0d latency", a, b), lat, elat);
    chk($sformatf("%0d/%0d busy", a, b), bcyc, elat + 1);
    chk($sformatf("%0d/%0d quotient", a, b), quotient, eq);
    chk($sformatf("%0d/%0d remainder", a, b), remainder, er);
    chk($sformatf("%0d/%0d dbz", a, b), div_by_zero, ez);
    @(posedge clk);
    #1 start = 1'b0;
    chk($sformatf("%0d/%0d done pulse", a, b), done, 1'b0);
    @(posedge clk);
    #1 chk($sformatf("%0d/%0d idle after", a, b), busy, 1'b0);
    chk($sformatf("%0d/%0d q held", a, b), quotient, eq);
    chk($sformatf("%0d/%0d r held", a, b), remainder, er);
  endtask
  initial begin
    #2 chk("reset busy", busy, 0);
    chk("reset q", quotient, 0);
    chk("reset r", remainder, 0);
    chk("reset dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(8'd100, 8'd7, 0, 8'd14, 8'd2, 0, 15 + E);
    run(8'd5, 8'd9, 0, 8'd0, 8'd5, 0, 1 + E);
    run(8'd0, 8'd3, 0, 8'd0, 8'd0, 0, 1 + E);
    run(8'd200, 8'd0, 0, 8'hFF, 8'd200, 1, 1);
    run(8'd10, 8'd5, 0, 8'd2, 8'd0, 0, 3 + E);
    run(8'd120, 8'd1, 1, 8'd120, 8'd0, 0, 121 + E);
`ifndef DIV_SIGNED_EN
    run(8'd255, 8'd1, 1, 8'd255, 8'd0, 0, 256);
`endif
    @(negedge clk);
    dividend = 8'd100;
    divisor = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async rst busy", busy, 0);
    chk("async rst done", done, 0);
    chk("async rst q", quotient, 0);
    chk("async rst r", remainder, 0);
    chk("async rst dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(8'd9, 8'd4, 0, 8'd2, 8'd1, 0, 3 + E);
`ifdef DIV_SIGNED_EN
    run(8'h9C, 8'd7, 0, 8'hF2, 8'hFE, 0, 16);
    run(8'd100, 8'hF9, 0, 8'hF2, 8'h02, 0, 16);
    run(8'h80, 8'hFF, 0, 8'h80, 8'h00, 0, 130);
    run(8'h80, 8'h00, 0, 8'hFF, 8'h80, 1, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
